mips_state_sequencer: RTL

Multicycle state sequencer for the MIPS CPU core. Owns the registered 3-bit `state` consumed by the control-signal decoder and steps it through fetch, decode, execute, memory-access and write-back for each instruction. Stalls on memory `waitrequest`, skips write-back for instructions that do not need it, and halts the core when the PC reaches address 0. Also keeps retired-instruction and cycle counters for the testbench and debug.

---
 rtl/mips_state_sequencer.sv | 97 +++++++++
 1 files changed

// File: rtl/mips_state_sequencer.sv
// Multicycle state sequencer for the MIPS core: steps FETCH..WRITE_BACK per
// instruction, stalls on waitrequest, halts at HALT_ADDR, counts retirements and cycles.
module mips_state_sequencer #(
    parameter logic [31:0] HALT_ADDR = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [5:0]  opcode,
    input  logic [5:0]  func_code,
    input  logic        waitrequest,
    input  logic [31:0] pc,
    output logic [2:0]  state,
    output logic        active,
    output logic        instr_done,
    output logic [31:0] instr_count,
    output logic [31:0] cycle_count
);

    typedef enum logic [2:0] {
        S_FETCH      = 3'b000,
        S_DECODE     = 3'b001,
        S_EXECUTE    = 3'b010,
        S_MEM_ACCESS = 3'b011,
        S_WRITE_BACK = 3'b100,
        S_HALTED     = 3'b101
    } state_t;

    state_t      state_q, state_d;
    logic [31:0] instr_cnt_q;
    logic [31:0] cycle_cnt_q;
    logic        is_load;
    logic        is_store;
    logic        mem_stall;
    logic        boundary;
    state_t      boundary_next;

    // func_code only feeds the external debug trace, never the sequencing.
    logic unused_func_code;
    assign unused_func_code = ^func_code;

    always_comb begin
        // NOTE: every signal written here gets a default first so no latch is inferred.
        is_load  = 1'b0;
        is_store = 1'b0;
        case (opcode)
            6'b100000, 6'b100001, 6'b100010, 6'b100011,
            6'b100100, 6'b100101, 6'b100110: is_load  = 1'b1;
            6'b101000, 6'b101001, 6'b101011: is_store = 1'b1;
            default: ;
        endcase
    end

    assign mem_stall     = (is_load || is_store) && waitrequest;
    assign boundary      = ((state_q == S_MEM_ACCESS) && !mem_stall && !is_load)
                        || (state_q == S_WRITE_BACK);
    assign boundary_next = (pc == HALT_ADDR) ? S_HALTED : S_FETCH;

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_FETCH:      state_d = waitrequest ? S_FETCH : S_DECODE;
            S_DECODE:     state_d = S_EXECUTE;
            S_EXECUTE:    state_d = S_MEM_ACCESS;
            S_MEM_ACCESS: begin
                if (mem_stall)    state_d = S_MEM_ACCESS;
                else if (is_load) state_d = S_WRITE_BACK;
                else              state_d = boundary_next;
            end
            S_WRITE_BACK: state_d = boundary_next;
            S_HALTED:     state_d = S_HALTED;
            default:      state_d = S_FETCH;
        endcase
    end

    // NOTE: reset is sampled on the clock edge, so it lives inside the clocked branch.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= S_FETCH;
            instr_cnt_q <= 32'd0;
            cycle_cnt_q <= 32'd0;
        end else begin
            // NOTE: sequential state uses non-blocking assignments so every flop sees pre-edge values.
            state_q <= state_d;
            if (boundary)
                instr_cnt_q <= instr_cnt_q + 32'd1;
            if (state_q != S_HALTED)
                cycle_cnt_q <= cycle_cnt_q + 32'd1;
        end
    end

    assign state       = state_q;
    assign active      = (state_q != S_HALTED);
    assign instr_done  = boundary;
    assign instr_count = instr_cnt_q;
    assign cycle_count = cycle_cnt_q;

endmodule
